// File: rtl/sprite_spawn_pkg.sv
// Shared helpers for the sprite trajectory generator: step-index sizing and
// the elaboration-time check on the step count.
package sprite_spawn_pkg;

    // k runs 0..STEP inclusive, so it needs one bit beyond log2(STEP).
    function automatic int k_width(input int step);
        return $clog2(step) + 1;
    endfunction

    function automatic bit step_ok(input int step);
        return (step >= 2) && ((step & (step - 1)) == 0);
    endfunction

    localparam int DEFAULT_OFFSET_W = 12;
    localparam int DEFAULT_STEP     = 32;

endpackage

// File: rtl/sprite_spawn_axis_lerp.sv
// One axis of the trajectory: SRC + floor((DST-SRC)*k / STEP), wrapped to W bits.
module axis_lerp
    import sprite_spawn_pkg::*;
#(
    parameter int                    W    = DEFAULT_OFFSET_W,
    parameter logic signed [W-1:0]   SRC  = '0,
    parameter logic signed [W-1:0]   DST  = '0,
    parameter int                    STEP = DEFAULT_STEP,
    parameter int                    KW   = k_width(STEP)
) (
    input  logic [KW-1:0] i_k,
    output logic [W-1:0]  o_offset
);

    localparam int L  = $clog2(STEP);
    localparam int PW = W + L + 2;

    logic signed [W:0]    w_delta;
    logic signed [PW-1:0] w_delta_ext;
    logic signed [PW-1:0] w_k_ext;
    logic signed [PW-1:0] w_prod;

    assign w_delta     = {DST[W-1], DST} - {SRC[W-1], SRC};
    assign w_delta_ext = PW'(w_delta);
    assign w_k_ext     = $signed(PW'(i_k));
    assign w_prod      = w_delta_ext * w_k_ext;

    // Arithmetic shift floors toward minus infinity for negative deltas.
    assign o_offset = SRC + W'(w_prod >>> L);

endmodule

// File: rtl/sprite_spawn.sv
// Spawn controller: on en while idle, steps k from 0 to STEP one clock at a
// time and presents the interpolated (h,v) offset pair for a sprite layer.
module sprite_spawn
    import sprite_spawn_pkg::*;
#(
    parameter int                         HWIDTH = 12,
    parameter int                         VWIDTH = 12,
    parameter logic signed [HWIDTH-1:0]   HSRC   = '0,
    parameter logic signed [VWIDTH-1:0]   VSRC   = '0,
    parameter logic signed [HWIDTH-1:0]   HDST   = '0,
    parameter logic signed [VWIDTH-1:0]   VDST   = '0,
    parameter int                         STEP   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [HWIDTH-1:0] hoffset,
    output logic [VWIDTH-1:0] voffset,
    output logic              active
);

    localparam int            KW     = k_width(STEP);
    localparam logic [KW-1:0] STEP_K = KW'(STEP);

    generate
        if (!step_ok(STEP)) begin : g_bad_step
            $error("sprite_spawn: STEP must be a power of two and at least 2");
        end
    endgenerate

    logic          r_active;
    logic [KW-1:0] r_k;
    logic          w_active_next;
    logic [KW-1:0] w_k_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_k      <= '0;
        end else begin
            r_active <= w_active_next;
            r_k      <= w_k_next;
        end
    end

    // k is held at 0 whenever idle, so the lerp parks the outputs at the source.
    always_comb begin
        w_active_next = r_active;
        w_k_next      = r_k;
        if (r_active) begin
            if (r_k == STEP_K) begin
                w_active_next = 1'b0;
                w_k_next      = '0;
            end else begin
                w_k_next = r_k + 1'b1;
            end
        end else if (en) begin
            w_active_next = 1'b1;
            w_k_next      = '0;
        end
    end

    assign active = r_active;

    axis_lerp #(
        .W    (HWIDTH),
        .SRC  (HSRC),
        .DST  (HDST),
        .STEP (STEP),
        .KW   (KW)
    ) u_h_lerp (
        .i_k      (r_k),
        .o_offset (hoffset)
    );

    axis_lerp #(
        .W    (VWIDTH),
        .SRC  (VSRC),
        .DST  (VDST),
        .STEP (STEP),
        .KW   (KW)
    ) u_v_lerp (
        .i_k      (r_k),
        .o_offset (voffset)
    );

endmodule

// File: tb/tb_sprite_spawn.sv
// Scoreboard bench for sprite_spawn: a schedule-based model predicts each
// clock's outputs, a monitor process compares them against two DUT instances.
module tb_sprite_spawn;

    localparam int STEP = 32;
    localparam int HS = -80, VS = -140, HD = -120, VD = 220;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [11:0] h1, v1, h2, v2;
    logic        a1, a2;

    always #5 clk = ~clk;

    sprite_spawn #(
        .HWIDTH(12), .VWIDTH(12),
        .HSRC(-12'sd80), .VSRC(-12'sd140), .HDST(-12'sd120), .VDST(12'sd220),
        .STEP(STEP)
    ) dut_main (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hoffset(h1), .voffset(v1), .active(a1)
    );

    sprite_spawn #(
        .HWIDTH(12), .VWIDTH(12),
        .HSRC(12'sd0), .VSRC(-12'sd140), .HDST(12'sd0), .VDST(12'sd220),
        .STEP(STEP)
    ) dut_zero (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hoffset(h2), .voffset(v2), .active(a2)
    );

    typedef struct {
        logic        act;
        logic [11:0] h1, v1, h2, v2;
        int          tag;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   n_vec = 0;
    int   n_bad = 0;
    int   edge_n = 0;
    int   run_start = -1;

    // floor((dst-src)*k/STEP) with plain integer arithmetic, wrapped to 12 bits
    function automatic logic [11:0] lerp(input int src, input int dst, input int k);
        int num, q_i;
        num = (dst - src) * k;
        q_i = num / STEP;
        if (num < 0 && (num % STEP) != 0) q_i = q_i - 1;
        return 12'(src + q_i);
    endfunction

    function automatic bit in_run(input int m);
        return (run_start >= 0) && (m >= run_start) && (m - run_start <= STEP);
    endfunction

    function automatic exp_t expect_at(input int m);
        exp_t e;
        int   k;
        k     = in_run(m) ? (m - run_start) : 0;
        e.act = in_run(m);
        e.h1  = lerp(HS, HD, k);
        e.v1  = lerp(VS, VD, k);
        e.h2  = lerp(0, 0, k);
        e.v2  = lerp(VS, VD, k);
        e.tag = m;
        return e;
    endfunction

    task automatic cmp(input string name, input int tag, input logic [11:0] act_v,
                       input logic [11:0] exp_v);
        n_vec++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s edge=%0d got=0x%03h want=0x%03h", name, tag, act_v, exp_v);
        end
    endtask

    // Monitor: one expected entry per clock edge, plus entries for async resets.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("active",   e.tag, 12'(a1), 12'(e.act));
                cmp("hoffset",  e.tag, h1, e.h1);
                cmp("voffset",  e.tag, v1, e.v1);
                cmp("active_z", e.tag, 12'(a2), 12'(e.act));
                cmp("hoffset_z", e.tag, h2, e.h2);
                cmp("voffset_z", e.tag, v2, e.v2);
                $display("edge %0d rst_n=%0b en=%0b act=%0b h=%0d v=%0d hz=%0d",
                         e.tag, rst_n, en, a1, $signed(h1), $signed(v1), $signed(h2));
            end
        end
    end

    // Drive one clock's inputs at the negedge and predict the following edge.
    task automatic step(input bit en_v, input bit rst_v);
        bit prev_rst;
        @(negedge clk);
        prev_rst = rst_n;
        rst_n = rst_v;
        en    = en_v;
        if (!rst_v) begin
            run_start = -1;
            if (prev_rst) begin
                q.push_back(expect_at(edge_n));
                -> chk_ev;
            end
        end
        edge_n++;
        if (rst_v && !in_run(edge_n - 1) && en_v) run_start = edge_n;
        q.push_back(expect_at(edge_n));
    endtask

    initial begin
        int guard;
        #2;
        q.push_back(expect_at(edge_n));
        -> chk_ev;
        repeat (2) step(0, 0);
        repeat (3) step(0, 1);

        // Single trigger, full run and return to idle
        step(1, 1);
        repeat (40) step(0, 1);

        // en held high: lockout and 34-clock period
        repeat (110) step(1, 1);
        repeat (3) step(0, 1);

        // Abort at k=10, then stay idle after release
        step(1, 1);
        repeat (10) step(0, 1);
        step(0, 0);
        repeat (2) step(0, 0);
        repeat (4) step(0, 1);

        // Random spawn requests with occasional resets
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 199) != 0);
        end
        repeat (3) step(0, 1);

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #3;
        if (q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
